// File: rtl/hazard_unit_mc_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : hazard_pkg                                              |
// | Desc   : Forward-select encodings and sequencer state type.      |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
package hazard_pkg;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mc_state_t;

endpackage
`default_nettype wire

// File: rtl/hazard_unit_mc_mc_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : mc_sequencer                                            |
// | Desc   : Holds a MUL/DIV in E for MC_LAT cycles, then pulses done.|
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module mc_sequencer
  import hazard_pkg::*;
#(
  parameter int MC_LAT = 8,
  parameter int CW     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic abort,
  output logic busy,
  output logic done
);

  localparam logic [CW-1:0] C_CNT_LOAD = CW'(MC_LAT - 2);

  mc_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  // Start cycle + (MC_LAT-2) BUSY cycles + DONE cycle = MC_LAT cycles in E.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          cnt_d   = C_CNT_LOAD;
          state_d = (C_CNT_LOAD == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (abort) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_d == '0) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule
`default_nettype wire

// File: rtl/hazard_unit_mc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : hazard_unit_mc                                          |
// | Desc   : Forwarding, load-use, branch and multi-cycle hazard ctrl.|
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int AW      = 4,
  parameter int PC_REG  = 15,
  parameter int MC_LAT  = 8,
  parameter int CW      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_SRC*AW-1:0] SrcAddrE,
  input  logic [NUM_SRC-1:0]    SrcUsedE,
  input  logic [NUM_SRC*AW-1:0] SrcAddrD,
  input  logic [NUM_SRC-1:0]    SrcUsedD,
  input  logic [AW-1:0]         WA3E,
  input  logic [AW-1:0]         WA3M,
  input  logic [AW-1:0]         WA3W,
  input  logic                  RegWriteE,
  input  logic                  RegWriteM,
  input  logic                  RegWriteW,
  input  logic                  MemtoRegE,
  input  logic                  McStartE,
  input  logic                  PCSrcD,
  input  logic                  PCSrcE,
  input  logic                  PCSrcM,
  input  logic                  PCSrcW,
  output logic [NUM_SRC*2-1:0]  ForwardE,
  output logic                  StallF,
  output logic                  StallD,
  output logic                  StallE,
  output logic                  FlushD,
  output logic                  FlushE,
  output logic                  FlushM,
  output logic                  McBusyE,
  output logic                  McDoneE
);

  localparam logic [AW-1:0] C_PC_REG = AW'(PC_REG);

  logic [NUM_SRC-1:0] w_ld_hit;
  logic               w_ld_stall;
  logic               w_bp;
  logic               w_mc_stall;
  logic               w_busy;
  logic               w_done;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_fwd
      logic [AW-1:0] w_addr;
      logic [1:0]    w_sel;
      assign w_addr = SrcAddrE[gi*AW +: AW];
      always_comb begin
        w_sel = FWD_RF;
        if (SrcUsedE[gi] && RegWriteM && (WA3M == w_addr) && (w_addr != C_PC_REG)) begin
          w_sel = FWD_M;
        end else if (SrcUsedE[gi] && RegWriteW && (WA3W == w_addr) && (w_addr != C_PC_REG)) begin
          w_sel = FWD_W;
        end
      end
      assign ForwardE[gi*2 +: 2] = reset ? FWD_RF : w_sel;
    end

    for (gi = 0; gi < NUM_SRC; gi++) begin : g_ld
      assign w_ld_hit[gi] = SrcUsedD[gi] && (SrcAddrD[gi*AW +: AW] == WA3E);
    end
  endgenerate

  assign w_ld_stall = MemtoRegE && RegWriteE && (|w_ld_hit);
  assign w_bp       = PCSrcD || PCSrcE || PCSrcM;

  mc_sequencer #(
    .MC_LAT (MC_LAT),
    .CW     (CW)
  ) u_seq (
    .clk   (clk),
    .reset (reset),
    .start (McStartE),
    .abort (PCSrcW),
    .busy  (w_busy),
    .done  (w_done)
  );

  // The IDLE start cycle already holds E; the DONE cycle lets the op advance.
  assign w_mc_stall = (!w_busy && McStartE && !PCSrcW) || (w_busy && !w_done);

  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushM = 1'b0;
    if (reset) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
      FlushM = 1'b1;
    end else if (PCSrcW) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (w_mc_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      FlushM = 1'b1;
    end else if (w_ld_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end else if (w_bp) begin
      StallF = 1'b1;
      FlushD = 1'b1;
    end
  end

  assign McBusyE = w_busy && !reset;
  assign McDoneE = w_done && !reset;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_mc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module : tb_hazard_unit_mc                                       |
// | Desc   : Directed scoreboard bench for hazard_unit_mc.           |
// | Rev    : 1.0                                                     |
// +------------------------------------------------------------------+
module tb_hazard_unit_mc;

  logic        clk;
  logic        reset;
  logic [15:0] SrcAddrE, SrcAddrD;
  logic [3:0]  SrcUsedE, SrcUsedD;
  logic [3:0]  WA3E, WA3M, WA3W;
  logic        RegWriteE, RegWriteM, RegWriteW, MemtoRegE, McStartE;
  logic        PCSrcD, PCSrcE, PCSrcM, PCSrcW;
  logic [7:0]  ForwardE;
  logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusyE, McDoneE;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];
  string       tag_q[$];

  hazard_unit_mc dut (
    .clk(clk), .reset(reset),
    .SrcAddrE(SrcAddrE), .SrcUsedE(SrcUsedE), .SrcAddrD(SrcAddrD), .SrcUsedD(SrcUsedD),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .McStartE(McStartE),
    .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
    .ForwardE(ForwardE), .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .McBusyE(McBusyE), .McDoneE(McDoneE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed layout: {fwd[7:0], sf, sd, se, fd, fe, fm, busy, done}
  function automatic logic [15:0] ev(input logic [7:0] fwd, input logic sf, input logic sd,
                                     input logic se, input logic fd, input logic fe,
                                     input logic fm, input logic busy, input logic done);
    return {fwd, sf, sd, se, fd, fe, fm, busy, done};
  endfunction

  // Expected controls for cycle k (1-based) of an undisturbed 8-cycle op.
  function automatic logic [15:0] mc_exp(input int k);
    if (k == 1)      return ev(8'h00, 1, 1, 1, 0, 0, 1, 0, 0);
    else if (k < 8)  return ev(8'h00, 1, 1, 1, 0, 0, 1, 1, 0);
    else             return ev(8'h00, 0, 0, 0, 0, 0, 0, 1, 1);
  endfunction

  task automatic push(input string tag, input logic [15:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    logic [15:0] obs;
    logic [15:0] e;
    string       t;
    obs = {ForwardE, StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusyE, McDoneE};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic check(input string tag, input logic [15:0] e);
    push(tag, e);
    @(negedge clk);
    pop_check();
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    SrcAddrE = '0; SrcAddrD = '0; SrcUsedE = '0; SrcUsedD = '0;
    WA3E = '0; WA3M = '0; WA3W = '0;
    RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0; McStartE = 0;
    PCSrcD = 0; PCSrcE = 0; PCSrcM = 0; PCSrcW = 0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    // Forwarding conditions active while in reset must still read as 00.
    WA3M = 4'd3; RegWriteM = 1; SrcAddrE = 16'h0003; SrcUsedE = 4'b0001;
    check("reset_state", ev(8'h00, 0, 0, 0, 1, 1, 1, 0, 0));
    next_cycle();
    reset = 1'b0;

    WA3W = 4'd3; RegWriteW = 1;
    check("fwd_m_priority", ev(8'h02, 0, 0, 0, 0, 0, 0, 0, 0));
    next_cycle();
    RegWriteM = 0;
    check("fwd_w", ev(8'h01, 0, 0, 0, 0, 0, 0, 0, 0));
    next_cycle();
    RegWriteM = 1; WA3M = 4'd15; WA3W = 4'd15; SrcAddrE = 16'h000F;
    check("fwd_pc_reg", ev(8'h00, 0, 0, 0, 0, 0, 0, 0, 0));
    next_cycle();
    // op3 hits M, op1 hits W, op0 matches M but is unused
    SrcAddrE = 16'h7447; SrcUsedE = 4'b1010; WA3M = 4'd7; WA3W = 4'd4;
    check("fwd_multi", ev(8'h84, 0, 0, 0, 0, 0, 0, 0, 0));
    next_cycle();

    clear_inputs();
    MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd5; SrcAddrD = 16'h0500; SrcUsedD = 4'b0100;
    check("load_use", ev(8'h00, 1, 1, 0, 0, 1, 0, 0, 0));
    next_cycle();
    SrcUsedD = 4'b0000;
    check("load_use_unused", ev(8'h00, 0, 0, 0, 0, 0, 0, 0, 0));
    next_cycle();
    clear_inputs();
    PCSrcD = 1;
    check("branch_pending_d", ev(8'h00, 1, 0, 0, 1, 0, 0, 0, 0));
    next_cycle();
    PCSrcD = 0; PCSrcM = 1;
    check("branch_pending_m", ev(8'h00, 1, 0, 0, 1, 0, 0, 0, 0));
    next_cycle();
    MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd5; SrcAddrD = 16'h0500; SrcUsedD = 4'b0100;
    check("ld_over_bp", ev(8'h00, 1, 1, 0, 0, 1, 0, 0, 0));
    next_cycle();
    PCSrcW = 1;
    check("pcsrcw_override", ev(8'h00, 0, 0, 0, 1, 1, 0, 0, 0));
    next_cycle();
    clear_inputs();

    // Single multi-cycle op, McStartE held until the DONE cycle
    McStartE = 1;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("mc_cycle%0d", k), mc_exp(k));
      next_cycle();
      if (k == 8) McStartE = 0;
    end
    check("mc_after_done", ev(8'h00, 0, 0, 0, 0, 0, 0, 0, 0));
    next_cycle();

    // Load-use during BUSY, then abort on the third BUSY cycle
    McStartE = 1;
    check("abort_start", mc_exp(1));
    next_cycle();
    MemtoRegE = 1; RegWriteE = 1; WA3E = 4'd5; SrcAddrD = 16'h0500; SrcUsedD = 4'b0100;
    check("ld_during_busy", ev(8'h00, 1, 1, 1, 0, 0, 1, 1, 0));
    next_cycle();
    MemtoRegE = 0; RegWriteE = 0; SrcUsedD = 4'b0000;
    check("busy_cycle2", mc_exp(3));
    next_cycle();
    PCSrcW = 1;
    check("abort_cycle", ev(8'h00, 0, 0, 0, 1, 1, 0, 1, 0));
    next_cycle();
    PCSrcW = 0; McStartE = 0;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("post_abort%0d", k), ev(8'h00, 0, 0, 0, 0, 0, 0, 0, 0));
      next_cycle();
    end

    // Back-to-back ops: start held through DONE restarts immediately
    McStartE = 1;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("b2b_first%0d", k), mc_exp(k));
      next_cycle();
    end
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("b2b_second%0d", k), mc_exp(k));
      next_cycle();
    end
    // Fifth cycle of the second op is its fourth BUSY cycle
    check("pre_reset_busy", mc_exp(5));
    #2;
    reset = 1'b1;
    push("async_reset", ev(8'h00, 0, 0, 0, 1, 1, 1, 0, 0));
    #1;
    pop_check();
    next_cycle();
    check("reset_held", ev(8'h00, 0, 0, 0, 1, 1, 1, 0, 0));
    next_cycle();
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("fresh_op%0d", k), mc_exp(k));
      next_cycle();
      if (k == 8) McStartE = 0;
    end
    check("fresh_idle", ev(8'h00, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
